eject_buffer: RTL

EJECT_BUFFER -- requirements
Module: eject_buffer

---
 rtl/eject_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/eject_buffer.sv
// ============================================================================
// Module   : eject_buffer
// Brief    : DEPTH-entry ejection FIFO between the router ejection tree and
//            the local PE. Optional zero-latency bypass: EJECT_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IN_ROUTER_SIZE
`define IN_ROUTER_SIZE 16
`endif
`ifndef PROD_VECTOR_LOCAL
`define PROD_VECTOR_LOCAL 0
`endif

module eject_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [`IN_ROUTER_SIZE-1:0] flitIn,
    input  logic                       peReady,
    output logic [`IN_ROUTER_SIZE-1:0] flitOut,
    output logic                       flitOutValid,
    output logic                       ejectStall,
    output logic [PTR_W:0]             count,
    output logic                       overflow
);

    localparam int             FLIT_W = `IN_ROUTER_SIZE;
    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic in_v;
    logic buf_valid;
    logic full;
    logic bypass;
    logic pop;
    logic push;

    always_comb begin
        in_v      = flitIn[`PROD_VECTOR_LOCAL];
        buf_valid = (count_q != '0);
        full      = (count_q == C_FULL);
`ifdef EJECT_BYPASS_EN
        // An empty buffer with a ready PE hands the flit straight through.
        bypass    = !buf_valid && in_v && peReady;
`else
        bypass    = 1'b0;
`endif
        pop       = buf_valid && peReady;
        push      = in_v && (!full || pop) && !bypass;

        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d = overflow_q || (in_v && full && !pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left uninitialised; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flitIn;
        end
    end

    always_comb begin
        if (bypass) begin
            flitOut = flitIn;
        end else if (buf_valid) begin
            flitOut = mem_q[rd_ptr_q];
        end else begin
            flitOut = '0;
        end
        flitOutValid = buf_valid || bypass;
        ejectStall   = full;
        count        = count_q;
        overflow     = overflow_q;
    end

endmodule

`default_nettype wire
